// File: rtl/tdm_demux_sequencer.sv
// rtl/tdm_demux_sequencer.sv - serial TDM to 16-way demux slot sequencer with sync tracking
// Optional frame parity checking is built when FRAME_PARITY_EN is defined.
module tdm_demux_sequencer #(
    parameter int NUM_SLOTS = 16,
    parameter int SEL_W     = 4,
    parameter int SLOT_HOLD = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    input  logic             i_frame_sync,
    output logic             o_bit_ready,
    output logic             o_data_in_16,
    output logic [SEL_W-1:0] o_select_4,
    output logic             o_slot_strobe,
    output logic             o_frame_done,
    output logic             o_sync_err,
    output logic             o_parity_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD      = 8'(SLOT_HOLD);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_slot;
    logic [SEL_W-1:0] w_slot_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] w_present_slot;
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_nxt;
    logic             r_data;
    logic             w_data_nxt;
    logic             r_strobe;
    logic             w_strobe_nxt;
    logic             r_frame_done;
    logic             w_frame_done_nxt;
    logic             r_sync_err;
    logic             w_sync_err_nxt;
    logic             w_present;
    logic             w_ready;
    logic             w_xfer;

    // r_hold counts remaining hold cycles including the current one; a new bit
    // may be taken in the final hold cycle so slots follow back to back.
    assign w_ready = i_enable && (r_state != ST_IDLE) && (r_hold <= 8'd1);
    assign w_xfer  = i_bit_valid && w_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_sel_nxt        = r_sel;
        w_data_nxt       = r_data;
        w_hold_nxt       = (r_hold != 8'd0) ? (r_hold - 8'd1) : 8'd0;
        w_strobe_nxt     = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_present        = 1'b0;
        w_present_slot   = r_slot;
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_slot_nxt  = '0;
            w_sel_nxt   = '0;
            w_data_nxt  = 1'b0;
            w_hold_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (w_xfer && i_frame_sync) begin
                        w_present      = 1'b1;
                        w_present_slot = '0;
                        w_state_nxt    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (i_frame_sync && (r_slot != '0)) begin
                            w_sync_err_nxt = 1'b1;
                            w_present      = 1'b1;
                            w_present_slot = '0;
                        end else if (!i_frame_sync && (r_slot == '0)) begin
                            // Lost the frame marker: drop the bit and hunt for sync again.
                            w_sync_err_nxt = 1'b1;
                            w_state_nxt    = ST_WAIT_SYNC;
                            w_slot_nxt     = '0;
                            w_sel_nxt      = '0;
                            w_data_nxt     = 1'b0;
                            w_hold_nxt     = 8'd0;
                        end else begin
                            w_present = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            if (w_present) begin
                w_data_nxt       = i_bit_in;
                w_sel_nxt        = w_present_slot;
                w_strobe_nxt     = 1'b1;
                w_frame_done_nxt = (w_present_slot == LAST_SLOT);
                w_hold_nxt       = HOLD;
                w_slot_nxt       = w_present_slot + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot       <= '0;
            r_sel        <= '0;
            r_data       <= 1'b0;
            r_hold       <= 8'd0;
            r_strobe     <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_slot       <= w_slot_nxt;
            r_sel        <= w_sel_nxt;
            r_data       <= w_data_nxt;
            r_hold       <= w_hold_nxt;
            r_strobe     <= w_strobe_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sync_err   <= w_sync_err_nxt;
        end
    end

`ifdef FRAME_PARITY_EN
    logic r_par;
    logic w_par_nxt;
    logic r_parity_err;
    logic w_parity_err_nxt;
    logic w_acc;

    // Slot 0 restarts the running XOR, which also covers realignment.
    assign w_acc = (w_present_slot == '0) ? i_bit_in : (r_par ^ i_bit_in);

    always_comb begin
        w_par_nxt        = r_par;
        w_parity_err_nxt = 1'b0;
        if (!i_enable) begin
            w_par_nxt = 1'b0;
        end else if (w_present) begin
            if (w_present_slot == LAST_SLOT) begin
                w_parity_err_nxt = w_acc;
                w_par_nxt        = 1'b0;
            end else begin
                w_par_nxt = w_acc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par        <= w_par_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_bit_ready   = w_ready;
    assign o_data_in_16  = r_data;
    assign o_select_4    = r_sel;
    assign o_slot_strobe = r_strobe;
    assign o_frame_done  = r_frame_done;
    assign o_sync_err    = r_sync_err;

endmodule

// File: doc/tdm_demux_sequencer.md
Name: tdm_demux_sequencer

Overview:
Upstream feeder for the 16-way demultiplexer in the wireless receive path. Accepts a serial TDM bit stream with a frame-sync marker and a valid/ready handshake. Assigns each accepted bit to a slot 0..15 and drives the demux data_in_16 / select_4 pair, holding each slot for a programmable number of clocks. Tracks frame alignment and flags sync errors and completed frames.

Parameters:
NUM_SLOTS, 16, slots per frame; must equal 2**SEL_W.
SEL_W, 4, select width; matches demux select_4.
SLOT_HOLD, 1, clocks each slot is presented on the outputs; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  sequencer run enable
bit_in  input  1  serial TDM data bit
bit_valid  input  1  bit_in valid
frame_sync  input  1  qualifies bit_in as slot 0 of a frame; sampled only with bit_valid
bit_ready  output  1  sequencer accepts a bit this cycle
data_in_16  output  1  data to demux, registered
select_4  output  SEL_W  slot index to demux, registered
slot_strobe  output  1  one-cycle pulse on the first cycle a new slot is presented
frame_done  output  1  one-cycle pulse when slot NUM_SLOTS-1 is presented
sync_err  output  1  one-cycle pulse on frame misalignment
parity_err  output  1  one-cycle pulse on frame parity failure; constant 0 without FRAME_PARITY_EN

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; slot counter 0; hold counter 0.
- A transfer occurs when bit_valid=1 and bit_ready=1 in the same cycle.
- States:
  - IDLE:
    - bit_ready=0; data_in_16=0, select_4=0.
    - enable=1 -> WAIT_SYNC on the next clock.
  - WAIT_SYNC:
    - bit_ready=1.
    - Transfer with frame_sync=0: bit discarded, outputs unchanged.
    - Transfer with frame_sync=1: present as slot 0 and go to RUN.
  - RUN:
    - Each transfer presents the next slot.
    - Slot counter increments by 1 and wraps from NUM_SLOTS-1 to 0.
- Presentation:
  - Transfer in cycle N -> data_in_16=bit_in and select_4=slot index from cycle N+1.
  - slot_strobe=1 in cycle N+1 only.
  - Values are held for exactly SLOT_HOLD cycles, N+1..N+SLOT_HOLD.
  - After the hold expires with no new transfer, data_in_16 and select_4 retain their last values.
- bit_ready in WAIT_SYNC/RUN:
  - Deasserted during hold cycles 1..SLOT_HOLD-1 of a slot.
  - Reasserted in the final hold cycle, giving back-to-back throughput of one bit per SLOT_HOLD clocks.
  - SLOT_HOLD=1: bit_ready stays 1.
- frame_done: pulses together with slot_strobe when slot NUM_SLOTS-1 is presented.
- Alignment:
  - frame_sync=1 on a RUN transfer whose expected slot is not 0:
    - sync_err pulses in cycle N+1.
    - The bit is re-presented as slot 0; counter realigns; stay in RUN.
  - frame_sync=0 on a RUN transfer whose expected slot is 0:
    - sync_err pulses.
    - Bit discarded, no slot_strobe.
    - State -> WAIT_SYNC; data_in_16 forced 0, select_4 forced 0.
- enable=0 in any state:
  - Next clock: IDLE, outputs 0, counters cleared.
  - Any in-progress hold is abandoned.
  - No frame_done or sync_err is generated.
- Reset mid-frame: immediate return to reset values; no pulses emitted.
- Simultaneous events:
  - enable=0 has priority over a transfer in the same cycle; the bit is not accepted.
  - sync_err and frame_done never coincide, because a realign always presents slot 0.

Optional Feature:
Macro FRAME_PARITY_EN.
- Defined:
  - Running XOR over slots 0..NUM_SLOTS-2 of the current frame.
  - Slot NUM_SLOTS-1 carries even parity.
  - On presentation of slot NUM_SLOTS-1, if XOR(all 16 bits) != 0, parity_err pulses in the same cycle as frame_done.
  - The accumulator clears at each slot 0 and on any realign.
- Not defined: no accumulator logic; parity_err tied to 0.

Test Plan:
1. Reset, then enable=1, SLOT_HOLD=1; stream 16 bits 1,0,0,1,... with frame_sync on the first bit -> select_4 steps 0..15 one per clock, data_in_16 follows the bits one clock later, frame_done pulses once at select_4=4'b1111.
2. SLOT_HOLD=3 with bit_valid held high -> each select_4 value is held 3 cycles; bit_ready pattern is 0,0,1 repeating; slot_strobe fires once per slot.
3. WAIT_SYNC with 5 bits at frame_sync=0, then frame_sync=1 with bit_in=1 -> first 5 bits ignored (select_4=0, data_in_16=0, no strobe); next cycle select_4=0, data_in_16=1, slot_strobe=1.
4. RUN at slot 9 (select_4=4'b1001), next transfer has frame_sync=1 -> sync_err=1, select_4=0. Separately, at end of frame the next bit has frame_sync=0 -> sync_err=1, state WAIT_SYNC, outputs 0.
5. Assert rst at slot 6 with SLOT_HOLD=4 mid-hold -> all outputs 0 in the same cycle. Separately, drop enable mid-frame -> IDLE next clock, bit_ready=0, no frame_done.
6. FRAME_PARITY_EN defined, frame of 16 bits with odd total ones -> parity_err=1 coincident with frame_done. Even-parity frame -> parity_err stays 0. Macro undefined -> parity_err always 0.
